// File: rtl/pipelined_rca_adder_pkg.sv
// Shared constants and geometry helpers for the pipelined ripple-carry add/subtract unit.
package pipelined_rca_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  // A single-stage build would have no carry register between slices.
  function automatic bit geom_ok(input int width, input int stages);
    return (stages >= 2) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_rca_adder_if.sv
// Operand/result handshake bundle between the ALU operand mux and writeback.
interface pipelined_rca_adder_if
  import pipelined_rca_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, data_operandA, data_operandB, sub, out_ready,
    input  in_ready, out_valid, data_result, carry_out, overflow
  );

  modport slave (
    input  in_valid, data_operandA, data_operandB, sub, out_ready,
    output in_ready, out_valid, data_result, carry_out, overflow
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of every ripple slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipelined_rca_adder_slice.sv
// Combinational SW-bit ripple adder; also exposes the carry into its top bit for overflow detection.
module pipelined_rca_adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co,
  output logic          c_msb_in
);
  logic [SW:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SW; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co       = c[SW];
  assign c_msb_in = c[SW-1];
endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry add/subtract, one SW-bit slice per stage, global stall on backpressure.
// Optional signed saturation on overflow: define PIPELINED_RCA_ADDER_SAT_EN.
module pipelined_rca_adder
  import pipelined_rca_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic                 clock,
  input  logic                 reset,
  pipelined_rca_adder_if.slave bus
);
  localparam int SW = slice_w(WIDTH, STAGES);

  if (!geom_ok(WIDTH, STAGES)) begin : g_geom_check
    $error("pipelined_rca_adder: WIDTH must be a multiple of STAGES, STAGES >= 2");
  end

`ifdef PIPELINED_RCA_ADDER_SAT_EN
  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] sum,
                                                       input logic ovf,
                                                       input logic a_msb,
                                                       input logic b_msb);
    if (!ovf) return sum;
    return (!a_msb && !b_msb) ? SAT_MAX : SAT_MIN;
  endfunction
`endif

  function automatic logic [WIDTH-1:0] insert_slice(input logic [WIDTH-1:0] r,
                                                    input logic [SW-1:0]    s,
                                                    input int               idx);
    insert_slice                = r;
    insert_slice[idx*SW +: SW]  = s;
  endfunction

  logic              stall;
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  a_st  [STAGES];
  logic [WIDTH-1:0]  b_st  [STAGES];
  logic [WIDTH-1:0]  r_st  [STAGES];
  logic              c_st  [STAGES];
  logic [SW-1:0]     s_w   [STAGES];
  logic              co_w  [STAGES];
  logic              cm_w  [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES-1];
  logic [WIDTH-1:0]  b_q   [STAGES-1];
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] c_q;
  logic              ovf_d;
  logic              ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_st[k] = bus.data_operandA;
      assign b_st[k] = bus.sub ? ~bus.data_operandB : bus.data_operandB;
      assign c_st[k] = bus.sub;
      assign r_st[k] = '0;
    end else begin : g_body
      // Skewed operands and de-skewed partial result arrive from the previous stage.
      assign a_st[k] = a_q[k-1];
      assign b_st[k] = b_q[k-1];
      assign c_st[k] = c_q[k-1];
      assign r_st[k] = res_q[k-1];
    end

    pipelined_rca_adder_slice #(.SW(SW)) u_slice (
      .a        (a_st[k][k*SW +: SW]),
      .b        (b_st[k][k*SW +: SW]),
      .ci       (c_st[k]),
      .s        (s_w[k]),
      .co       (co_w[k]),
      .c_msb_in (cm_w[k])
    );

    assign c_d[k] = co_w[k];

    if (k == STAGES-1) begin : g_tail
      assign ovf_d = co_w[k] ^ cm_w[k];
`ifdef PIPELINED_RCA_ADDER_SAT_EN
      assign res_d[k] = saturate(insert_slice(r_st[k], s_w[k], k), ovf_d,
                                 a_st[k][WIDTH-1], b_st[k][WIDTH-1]);
`else
      assign res_d[k] = insert_slice(r_st[k], s_w[k], k);
`endif
    end else begin : g_mid
      assign res_d[k] = insert_slice(r_st[k], s_w[k], k);
    end
  end

  assign stall         = vld_q[STAGES-1] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.data_result = res_q[STAGES-1];
  assign bus.carry_out = c_q[STAGES-1];
  assign bus.overflow  = ovf_q;

  // Stage boundary: every stage register advances together unless the output is stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) res_q[k] <= '0;
      for (int k = 0; k < STAGES-1; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (!stall) begin
      vld_q <= {vld_q[STAGES-2:0], bus.in_valid};
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) res_q[k] <= res_d[k];
      for (int k = 0; k < STAGES-1; k++) begin
        a_q[k] <= a_st[k];
        b_q[k] <= b_st[k];
      end
    end
  end

endmodule
